tft_timing_receiver: RTL and testbench
======================================

// Module: tft_timing_receiver
// PURPOSE
//  Sink-side counterpart of the TFT timing generator: samples an RGB565 TFT bus (HSYNC/VSYNC/DE/RGB),
//  measures line/frame timing, locks onto the expected 480x272 format and emits a coordinate-tagged
//  pixel stream (pixel_x/pixel_y/pixel_data). Used for loopback self-check of the display path and as
//  the front end of a frame-capture path. Single clock domain, the panel pixel clock.
// PARAMETERS
//  H_TOTAL_EXP  10'd525  expected clocks per line (HSYNC rise to HSYNC rise)
//  V_TOTAL_EXP  10'd286  expected lines per frame (VSYNC rise to VSYNC rise)
//  H_VALID      10'd480  expected DE-high clocks per active line
//  V_VALID      10'd272  expected active lines per frame
//  LOCK_FRAMES  2'd2     consecutive good frames needed to lock
// PORTS
//  tft_clock_9m      in   1   pixel clock; all logic on rising edge
//  system_reset      in   1   synchronous, active-high reset
//  horizontal_sync   in   1   HSYNC, active-high
//  vertical_sync     in   1   VSYNC, active-high
//  tft_data_enable   in   1   DE, active-high
//  rgb_tft           in   16  RGB565 pixel data, valid when DE=1
//  pixel_data        out  16  captured pixel
//  pixel_valid       out  1   pixel_data/pixel_x/pixel_y valid this cycle
//  pixel_x           out  10  column 0..H_VALID-1; 10'h3ff when pixel_valid=0
//  pixel_y           out  10  row 0..V_VALID-1; 10'h3ff when pixel_valid=0
//  frame_start       out  1   one-cycle pulse on VSYNC rise while locked
//  measured_h_total  out  10  last measured line period, clocks
//  measured_v_total  out  10  last measured frame period, lines
//  locked            out  1   format lock
//  timing_error      out  1   one-cycle pulse on any mismatch while locked
// BEHAVIOUR
//  - Reset (sync): all outputs 0 except pixel_x/pixel_y=10'h3ff; counters 0; FSM=SEARCH; input regs 0.
//  - Stage 1: register all inputs. Rise detect on registered HSYNC/VSYNC (prev 0, now 1).
//  - hcnt: 0 on HSYNC rise, else +1 saturating at 1023. On HSYNC rise: measured_h_total<=hcnt+1
//    (1023 if saturated). xcnt: DE-high clocks since HSYNC rise; cleared on HSYNC rise; saturates 1023.
//  - vcnt: 0 on VSYNC rise, else +1 per HSYNC rise, saturating 1023. On VSYNC rise:
//    measured_v_total<=vcnt+1. HSYNC and VSYNC rising same cycle is the normal case: both apply.
//  - ycnt: +1 on each DE falling edge; cleared on VSYNC rise. Line is "active" if DE seen in it.
//  - Line check at each HSYNC rise (for the line just ended): line_bad if measured period != H_TOTAL_EXP,
//    or active with xcnt != H_VALID. Frame check at VSYNC rise: frame_bad if any line_bad, or
//    vcnt+1 != V_TOTAL_EXP, or ycnt != V_VALID.
//  - FSM: SEARCH --VSYNC rise--> MEASURE (good_cnt=0; first partial frame never counted).
//    MEASURE at VSYNC rise: good -> good_cnt+1; reaching LOCK_FRAMES -> LOCKED; bad -> good_cnt=0.
//    LOCKED: line_bad at HSYNC rise or frame_bad at VSYNC rise -> SEARCH, timing_error=1 for that cycle.
//    locked = (state==LOCKED), registered.
//  - Pixel path: latency exactly 2 clocks from rgb_tft sample to pixel_data. pixel_valid=1 only in
//    LOCKED with DE=1 and xcnt<H_VALID and ycnt<V_VALID; overrun pixels dropped (pixel_valid=0,
//    treated as line_bad). pixel_x=xcnt, pixel_y=ycnt of that pixel.
//  - frame_start pulses 1 cycle after VSYNC rise detect, only while LOCKED (also the lock cycle).
//  - Reset mid-frame: everything re-initialises; re-lock takes partial + LOCK_FRAMES full frames.
// TESTING
//  1 Reset, drive nominal 525x286 timing (sync 41/10, back 2/2) -> locked=1 after 3rd VSYNC rise;
//    measured_h_total=525, measured_v_total=286.
//  2 Locked, first DE of frame, rgb_tft=16'hF800 -> 2 clocks later pixel_valid=1, x=0, y=0, data F800;
//    last pixel x=479, y=271; exactly 130560 pixel_valid cycles per frame.
//  3 Locked, one line shortened to 524 clocks -> timing_error pulse at next HSYNC rise, locked=0,
//    pixel_valid stays 0 until re-lock two full frames later.
//  4 Locked, DE held 481 clocks on one line -> 481st pixel dropped, timing_error, loss of lock.
//  5 HSYNC held low 1100 clocks -> hcnt saturates, measured_h_total=1023, no lock.
//  6 system_reset=1 one cycle mid-line while locked -> next cycle locked=0, pixel_x/y=3ff, all counters 0.

Source files
------------

// File: rtl/tft_timing_receiver.sv
// TFT bus receiver: measures HSYNC/VSYNC timing and locks onto the expected active format.
// Once locked, it emits coordinate-tagged pixels exactly two clocks after the bus is sampled.
module tft_timing_receiver #(
  parameter logic [9:0] H_TOTAL_EXP = 10'd525,
  parameter logic [9:0] V_TOTAL_EXP = 10'd286,
  parameter logic [9:0] H_VALID     = 10'd480,
  parameter logic [9:0] V_VALID     = 10'd272,
  parameter logic [1:0] LOCK_FRAMES = 2'd2
) (
  input  logic        tft_clock_9m,
  input  logic        system_reset,
  input  logic        horizontal_sync,
  input  logic        vertical_sync,
  input  logic        tft_data_enable,
  input  logic [15:0] rgb_tft,
  output logic [15:0] pixel_data,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [9:0]  measured_h_total,
  output logic [9:0]  measured_v_total,
  output logic        locked,
  output logic        timing_error,
  output logic [1:0]  fsm_state_o
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  state_t      state_q;
  logic [1:0]  good_cnt_q;
  logic        hs_q, vs_q, de_q, hs_prev_q, vs_prev_q, de_prev_q;
  logic [15:0] rgb_q;
  logic [9:0]  hcnt_q, xcnt_q, vcnt_q, ycnt_q;
  logic [9:0]  hcnt_d, xcnt_d, vcnt_d, ycnt_d;
  logic        ovr_q, ovr_d, acc_bad_q, acc_bad_d;
  logic [15:0] pixel_data_q;
  logic        pixel_valid_q, frame_start_q, locked_q, timing_error_q;
  logic [9:0]  pixel_x_q, pixel_y_q, meas_h_q, meas_v_q;

  logic        hs_rise, vs_rise, de_fall, pix_in_range, line_bad, frame_bad;
  logic [9:0]  h_period, v_period, x_eff, y_eff;
  logic [2:0]  good_next;

  always_comb begin
    hs_rise      = hs_q & ~hs_prev_q;
    vs_rise      = vs_q & ~vs_prev_q;
    de_fall      = de_prev_q & ~de_q;
    h_period     = sat_inc(hcnt_q);
    v_period     = sat_inc(vcnt_q);
    // Coordinates of the pixel currently in stage 1, after any sync-rise clear.
    x_eff        = hs_rise ? 10'd0 : xcnt_q;
    y_eff        = vs_rise ? 10'd0 : ycnt_q;
    pix_in_range = (x_eff < H_VALID) && (y_eff < V_VALID);
    line_bad     = (h_period != H_TOTAL_EXP) || ((xcnt_q != 10'd0) && (xcnt_q != H_VALID)) || ovr_q;
    frame_bad    = acc_bad_q || (hs_rise && line_bad) || (v_period != V_TOTAL_EXP) || (ycnt_q != V_VALID);
    hcnt_d       = hs_rise ? 10'd0 : h_period;
    xcnt_d       = de_q ? sat_inc(x_eff) : x_eff;
    vcnt_d       = vs_rise ? 10'd0 : (hs_rise ? v_period : vcnt_q);
    ycnt_d       = de_fall ? sat_inc(y_eff) : y_eff;
    ovr_d        = (hs_rise ? 1'b0 : ovr_q) | (de_q & ~pix_in_range);
    acc_bad_d    = vs_rise ? 1'b0 : (acc_bad_q | (hs_rise & line_bad));
    good_next    = {1'b0, good_cnt_q} + 3'd1;
  end

  always_ff @(posedge tft_clock_9m) begin
    if (system_reset) begin
      state_q        <= SEARCH;
      good_cnt_q     <= 2'd0;
      {hs_q, vs_q, de_q, hs_prev_q, vs_prev_q, de_prev_q} <= 6'd0;
      rgb_q          <= 16'd0;
      hcnt_q         <= 10'd0;
      xcnt_q         <= 10'd0;
      vcnt_q         <= 10'd0;
      ycnt_q         <= 10'd0;
      ovr_q          <= 1'b0;
      acc_bad_q      <= 1'b0;
      pixel_data_q   <= 16'd0;
      pixel_valid_q  <= 1'b0;
      pixel_x_q      <= 10'h3ff;
      pixel_y_q      <= 10'h3ff;
      frame_start_q  <= 1'b0;
      meas_h_q       <= 10'd0;
      meas_v_q       <= 10'd0;
      locked_q       <= 1'b0;
      timing_error_q <= 1'b0;
    end else begin
      hs_q      <= horizontal_sync;
      vs_q      <= vertical_sync;
      de_q      <= tft_data_enable;
      rgb_q     <= rgb_tft;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      de_prev_q <= de_q;
      hcnt_q    <= hcnt_d;
      xcnt_q    <= xcnt_d;
      vcnt_q    <= vcnt_d;
      ycnt_q    <= ycnt_d;
      ovr_q     <= ovr_d;
      acc_bad_q <= acc_bad_d;
      if (hs_rise) meas_h_q <= h_period;
      if (vs_rise) meas_v_q <= v_period;
      // pixel_valid qualifies pixel_data/pixel_x/pixel_y for one cycle; there is no backpressure.
      pixel_data_q  <= rgb_q;
      pixel_valid_q <= (state_q == LOCKED) && de_q && pix_in_range;
      pixel_x_q     <= ((state_q == LOCKED) && de_q && pix_in_range) ? x_eff : 10'h3ff;
      pixel_y_q     <= ((state_q == LOCKED) && de_q && pix_in_range) ? y_eff : 10'h3ff;
      frame_start_q  <= 1'b0;
      timing_error_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (vs_rise) begin
            state_q    <= MEASURE;
            good_cnt_q <= 2'd0;
          end
        end
        MEASURE: begin
          if (vs_rise) begin
            if (frame_bad) begin
              good_cnt_q <= 2'd0;
            end else if (good_next >= {1'b0, LOCK_FRAMES}) begin
              state_q       <= LOCKED;
              locked_q      <= 1'b1;
              frame_start_q <= 1'b1;
              good_cnt_q    <= 2'd0;
            end else begin
              good_cnt_q <= good_next[1:0];
            end
          end
        end
        LOCKED: begin
          if ((hs_rise && line_bad) || (vs_rise && frame_bad)) begin
            state_q        <= SEARCH;
            locked_q       <= 1'b0;
            timing_error_q <= 1'b1;
          end else if (vs_rise) begin
            frame_start_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign pixel_data       = pixel_data_q;
  assign pixel_valid      = pixel_valid_q;
  assign pixel_x          = pixel_x_q;
  assign pixel_y          = pixel_y_q;
  assign frame_start      = frame_start_q;
  assign measured_h_total = meas_h_q;
  assign measured_v_total = meas_v_q;
  assign locked           = locked_q;
  assign timing_error     = timing_error_q;
  assign fsm_state_o      = state_q;

endmodule

// File: tb/tb_tft_timing_receiver.sv
// Bench for tft_timing_receiver on a scaled-down 24x10 format (12x6 active).
// A line/frame-level reference model predicts lock state, the pixel stream, and the error/frame pulses.
module tb_tft_timing_receiver;
  localparam int HT = 24, HV = 12, VT = 10, VV = 6;
  localparam int HS_W = 3, DE0 = 5, VS_W = 2, FIRST_ACT = 3, LOCK = 2;
  localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2;

  logic        clk = 1'b0, rst = 1'b1, hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [15:0] rgb = 16'd0;
  logic [15:0] pixel_data;
  logic        pixel_valid, frame_start, locked, timing_error;
  logic [9:0]  pixel_x, pixel_y, measured_h_total, measured_v_total;
  logic [1:0]  fsm_state;

  tft_timing_receiver #(
    .H_TOTAL_EXP(10'd24), .V_TOTAL_EXP(10'd10), .H_VALID(10'd12), .V_VALID(10'd6), .LOCK_FRAMES(2'd2)
  ) dut (
    .tft_clock_9m(clk), .system_reset(rst), .horizontal_sync(hs), .vertical_sync(vs),
    .tft_data_enable(de), .rgb_tft(rgb), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
    .measured_h_total(measured_h_total), .measured_v_total(measured_v_total),
    .locked(locked), .timing_error(timing_error), .fsm_state_o(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_checks = 0, n_fail = 0;
  logic [55:0] exp_q[$];
  logic [55:0] mon_e;
  int err_seen = 0, fs_seen = 0, pix_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (timing_error) err_seen++;
      if (frame_start) fs_seen++;
      if (pixel_valid) begin
        pix_total++;
        if (exp_q.size() == 0) begin
          check("pix_extra", 64'(pixel_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel", 64'({cyc[19:0], pixel_x, pixel_y, pixel_data}), 64'(mon_e));
        end
      end
    end
  end

  // reference model state
  int m_mode, m_good, m_lines, m_delines, prev_len, prev_de, prev_y, exp_mh, exp_mv;
  bit m_fbad, prev_known, f_known, h_known, v_known, force_f800;
  int err_exp = 0, fs_exp = 0;

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic model_reset();
    m_mode = M_SEARCH; m_good = 0; m_lines = 0; m_delines = 0; m_fbad = 0;
    prev_known = 0; f_known = 0; h_known = 0; v_known = 0;
  endtask

  // driver: one line, HSYNC rise at cycle 0; optional one-cycle reset at cycle rst_c
  task automatic drive_line(input int len, input int de_len, input bit vs_line, input bit frame_first,
                            input int rst_c);
    int y;
    bit lb, fbad, partial, de_now;
    logic [15:0] d;
    lb = 0;
    if (prev_known)
      lb = (sat(prev_len) != HT) || (prev_de != 0 && prev_de != HV) || (prev_de != 0 && prev_y >= VV);
    h_known = prev_known;
    exp_mh  = sat(prev_len);
    if (frame_first) begin
      fbad    = m_fbad || lb || (m_lines != VT) || (m_delines != VV);
      v_known = f_known;
      exp_mv  = sat(m_lines);
      case (m_mode)
        M_SEARCH:  begin m_mode = M_MEASURE; m_good = 0; end
        M_MEASURE: begin
          if (fbad) m_good = 0;
          else begin
            m_good++;
            if (m_good >= LOCK) begin m_mode = M_LOCKED; fs_exp++; end
          end
        end
        default: begin
          if (fbad) begin m_mode = M_SEARCH; err_exp++; end
          else fs_exp++;
        end
      endcase
      f_known = 1; m_lines = 1; m_delines = 0; m_fbad = 0;
    end else begin
      m_lines++;
      if (m_mode == M_LOCKED && lb) begin m_mode = M_SEARCH; err_exp++; end
      m_fbad = m_fbad || lb;
    end
    y = m_delines;
    partial = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == rst_c) begin
        rst = 1'b1;
        model_reset();
        partial = 1;
      end else begin
        rst = 1'b0;
      end
      if (rst_c >= 0 && c == rst_c + 1) begin
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_valid", 64'(pixel_valid), 64'd0);
        check("rst_pixel_x", 64'(pixel_x), 64'h3ff);
        check("rst_pixel_y", 64'(pixel_y), 64'h3ff);
        check("rst_meas_h", 64'(measured_h_total), 64'd0);
        check("rst_meas_v", 64'(measured_v_total), 64'd0);
      end
      de_now = (c >= DE0) && (c < DE0 + de_len);
      hs  = (c < HS_W);
      vs  = vs_line;
      de  = de_now;
      d   = 16'($urandom);
      if (de_now && c == DE0 && force_f800) begin
        d = 16'hF800;
        force_f800 = 0;
      end
      rgb = d;
      if (de_now && m_mode == M_LOCKED && (c - DE0) < HV && y < VV)
        exp_q.push_back({cyc[19:0] + 20'd2, 10'(c - DE0), 10'(y), d});
    end
    if (de_len > 0 && !partial) m_delines++;
    prev_len = len; prev_de = de_len; prev_y = y; prev_known = !partial;
    check("locked", 64'(locked), 64'(m_mode == M_LOCKED));
    check("timing_error_count", 64'(err_seen), 64'(err_exp));
    check("frame_start_count", 64'(fs_seen), 64'(fs_exp));
    check("pix_missing", 64'(exp_q.size()), 64'd0);
    check("idle_outputs", 64'({pixel_valid, pixel_x, pixel_y}), 64'({1'b0, 10'h3ff, 10'h3ff}));
    if (h_known && !partial) check("meas_h", 64'(measured_h_total), 64'(exp_mh));
    if (v_known && !partial) check("meas_v", 64'(measured_v_total), 64'(exp_mv));
  endtask

  task automatic drive_frame(input int bad_line, input int bad_len, input int de_line, input int de_val,
                             input bit count_pix, input int rst_line, input int rst_c);
    int p0, len, dl;
    p0 = pix_total;
    for (int l = 0; l < VT; l++) begin
      len = (l == bad_line) ? bad_len : HT;
      dl  = (l >= FIRST_ACT && l < FIRST_ACT + VV) ? HV : 0;
      if (l == de_line) dl = de_val;
      drive_line(len, dl, l < VS_W, l == 0, (l == rst_line) ? rst_c : -1);
    end
    if (count_pix) check("frame_pixels", 64'(pix_total - p0), 64'(HV * VV));
  endtask

  task automatic clean_frames(input int n);
    for (int i = 0; i < n; i++) drive_frame(-1, HT, -1, HV, 0, -1, -1);
  endtask

  initial begin
    int kind, bl, blen, dline, dval;
    model_reset();
    force_f800 = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(pixel_valid), 64'd0);
    check("reset_pixel_x", 64'(pixel_x), 64'h3ff);
    check("reset_pixel_y", 64'(pixel_y), 64'h3ff);
    check("reset_data", 64'(pixel_data), 64'd0);
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_pulses", 64'({frame_start, timing_error}), 64'd0);
    check("reset_meas", 64'({measured_h_total, measured_v_total}), 64'd0);

    // lock-up on nominal timing; the first locked pixel carries F800
    clean_frames(2);
    force_f800 = 1;
    drive_frame(-1, HT, -1, HV, 1, -1, -1);
    drive_frame(-1, HT, -1, HV, 1, -1, -1);

    // random faults mixed with clean frames
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 5);
      bl = -1; blen = HT; dline = -1; dval = HV;
      if (kind == 3) begin
        bl = $urandom_range(0, VT - 1);
        blen = ($urandom_range(0, 1) == 1) ? HT + int'($urandom_range(1, 4)) : HT - int'($urandom_range(1, 4));
      end else if (kind == 4) begin
        dline = $urandom_range(FIRST_ACT, FIRST_ACT + VV - 1);
        dval = ($urandom_range(0, 1) == 1) ? HV + 1 : HV - 1;
      end else if (kind == 5) begin
        dline = $urandom_range(FIRST_ACT, FIRST_ACT + VV - 1);
        dval = 0;
      end
      drive_frame(bl, blen, dline, dval, 0, -1, -1);
    end

    // short line while locked
    clean_frames(3);
    drive_frame(5, HT - 1, -1, HV, 0, -1, -1);
    // DE overrun by one pixel while locked
    clean_frames(3);
    drive_frame(-1, HT, 4, HV + 1, 0, -1, -1);
    // HSYNC absent for 1100 clocks: line period saturates
    clean_frames(3);
    drive_frame(4, HS_W + 1100, -1, HV, 0, -1, -1);
    // one-cycle reset mid-line while locked, then re-lock
    clean_frames(3);
    drive_frame(-1, HT, -1, HV, 0, 5, 20);
    clean_frames(3);
    drive_frame(-1, HT, -1, HV, 1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
